// File: rtl/hazard_ctrl.sv
// Stall/flush controller for a 5-stage MIPS pipeline: Tuse/Tnew data hazards,
// multiply/divide busy tracking and a stall-cycle performance counter.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] IR_M,
  output logic        Stall,
  output logic        IR_E_Clr,
  output logic        MD_Busy,
  output logic [31:0] Stall_Cnt
);

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  function automatic logic is_mul(input logic [31:0] ir);
    return ir[31:26] == OP_R && (ir[5:0] == F_MULT || ir[5:0] == F_MULTU);
  endfunction

  function automatic logic is_div(input logic [31:0] ir);
    return ir[31:26] == OP_R && (ir[5:0] == F_DIV || ir[5:0] == F_DIVU);
  endfunction

  function automatic logic is_hilo(input logic [31:0] ir);
    return ir[31:26] == OP_R && (ir[5:0] == F_MFHI || ir[5:0] == F_MFLO ||
                                 ir[5:0] == F_MTHI || ir[5:0] == F_MTLO);
  endfunction

  // Destination register; 0 means "writes nothing" and can never stall.
  function automatic logic [4:0] dst_of(input logic [31:0] ir);
    logic [4:0] d;
    d = 5'd0;
    case (ir[31:26])
      OP_R: if (ir[5:0] == F_ADDU || ir[5:0] == F_SUBU ||
                ir[5:0] == F_MFHI || ir[5:0] == F_MFLO) d = ir[15:11];
      OP_ORI, OP_LUI, OP_LW: d = ir[20:16];
      OP_JAL: d = 5'd31;
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] tnew_e_of(input logic [31:0] ir);
    logic [1:0] t;
    t = 2'd0;
    case (ir[31:26])
      OP_LW: t = 2'd2;
      OP_ORI, OP_LUI: t = 2'd1;
      OP_R: if (ir[5:0] == F_ADDU || ir[5:0] == F_SUBU ||
                ir[5:0] == F_MFHI || ir[5:0] == F_MFLO) t = 2'd1;
      default: t = 2'd0;
    endcase
    return t;
  endfunction

  logic [CNT_W-1:0] md_cnt;
  logic             rs_rd, rt_rd;
  logic [1:0]       rs_tuse, rt_tuse;
  logic [4:0]       rs_d, rt_d, dst_e, dst_m;
  logic [1:0]       tnew_e, tnew_m;
  logic             rs_hit, rt_hit, data_stall, md_stall;
  logic             unused_bits;

  assign unused_bits = ^{IR_D, IR_E, IR_M};

  assign rs_d   = IR_D[25:21];
  assign rt_d   = IR_D[20:16];
  assign dst_e  = dst_of(IR_E);
  assign dst_m  = dst_of(IR_M);
  assign tnew_e = tnew_e_of(IR_E);
  assign tnew_m = (IR_M[31:26] == OP_LW) ? 2'd1 : 2'd0;

  always_comb begin
    rs_rd   = 1'b0;
    rt_rd   = 1'b0;
    rs_tuse = 2'd0;
    rt_tuse = 2'd0;
    case (IR_D[31:26])
      OP_R: begin
        case (IR_D[5:0])
          F_ADDU, F_SUBU, F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            rs_rd = 1'b1; rs_tuse = 2'd1;
            rt_rd = 1'b1; rt_tuse = 2'd1;
          end
          F_MTHI, F_MTLO: begin
            rs_rd = 1'b1; rs_tuse = 2'd1;
          end
          F_JR: begin
            rs_rd = 1'b1; rs_tuse = 2'd0;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_LW: begin
        rs_rd = 1'b1; rs_tuse = 2'd1;
      end
      OP_SW: begin
        rs_rd = 1'b1; rs_tuse = 2'd1;
        rt_rd = 1'b1; rt_tuse = 2'd2;
      end
      OP_BEQ: begin
        rs_rd = 1'b1; rs_tuse = 2'd0;
        rt_rd = 1'b1; rt_tuse = 2'd0;
      end
      default: ;
    endcase
  end

  // W-stage producers are ignored: the register file forwards them.
  assign rs_hit = rs_rd && rs_d != 5'd0 &&
                  ((rs_d == dst_e && tnew_e > rs_tuse) ||
                   (rs_d == dst_m && tnew_m > rs_tuse));
  assign rt_hit = rt_rd && rt_d != 5'd0 &&
                  ((rt_d == dst_e && tnew_e > rt_tuse) ||
                   (rt_d == dst_m && tnew_m > rt_tuse));

  assign data_stall = rs_hit || rt_hit;
  assign md_stall   = (is_mul(IR_D) || is_div(IR_D) || is_hilo(IR_D)) &&
                      (MD_Busy || is_mul(IR_E) || is_div(IR_E));

  assign Stall    = Reset && (data_stall || md_stall);
  assign IR_E_Clr = Stall;
  assign MD_Busy  = md_cnt != '0;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      md_cnt    <= '0;
      Stall_Cnt <= 32'd0;
    end else begin
      if (is_mul(IR_E))
        md_cnt <= CNT_W'(MULT_CYCLES);
      else if (is_div(IR_E))
        md_cnt <= CNT_W'(DIV_CYCLES);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - 1'b1;
      if (Stall)
        Stall_Cnt <= Stall_Cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, mult/div busy, zero-register,
// store data and asynchronous reset scenarios with hand-computed expectations.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] ir_d, ir_e, ir_m;
  logic        stall, ir_e_clr, md_busy;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_cnt;

  hazard_ctrl dut (
    .Clk(clk), .Reset(rst_n), .IR_D(ir_d), .IR_E(ir_e), .IR_M(ir_m),
    .Stall(stall), .IR_E_Clr(ir_e_clr), .MD_Busy(md_busy), .Stall_Cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
    ir_d = d;
    ir_e = e;
    ir_m = m;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(rtype(0, 0, 3, 6'h12), rtype(1, 2, 0, 6'h18), 32'd0);
    checks++;
    if (stall !== 1'b0 || ir_e_clr !== 1'b0) begin
      failures++; $display("FAIL reset_stall: got %b/%b want 0/0", stall, ir_e_clr);
    end
    step();
    checks++;
    if (md_busy !== 1'b0 || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_state: busy=%b cnt=%0d want 0/0", md_busy, stall_cnt);
    end
    drive(32'd0, 32'd0, 32'd0);
    #2 rst_n = 1'b1;
    step();
    exp_cnt = 32'd0;
  endtask

  task automatic test_load_use();
    drive(rtype(1, 3, 2, 6'h21), itype(6'h23, 0, 1, 16'h0), 32'd0);
    checks++;
    if (stall !== 1'b1 || ir_e_clr !== 1'b1) begin
      failures++; $display("FAIL load_use_stall: got %b/%b want 1/1", stall, ir_e_clr);
    end
    step();
    drive(rtype(1, 3, 2, 6'h21), 32'd0, itype(6'h23, 0, 1, 16'h0));
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL load_use_release: got %b want 0", stall);
    end
    step();
    exp_cnt = exp_cnt + 32'd1;
    checks++;
    if (stall_cnt !== exp_cnt) begin
      failures++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_branch();
    drive(itype(6'h04, 1, 4, 16'h0), rtype(2, 3, 1, 6'h21), 32'd0);
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL beq_alu_e: got %b want 1", stall);
    end
    step();
    drive(itype(6'h04, 1, 4, 16'h0), 32'd0, rtype(2, 3, 1, 6'h21));
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL beq_alu_m: got %b want 0", stall);
    end
    step();
    drive(itype(6'h04, 1, 0, 16'h0), 32'd0, itype(6'h23, 0, 1, 16'h0));
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL beq_lw_m: got %b want 1", stall);
    end
    step();
    drive(rtype(31, 0, 0, 6'h08), {6'h03, 26'h0000040}, 32'd0);
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL jr_jal: got %b want 0", stall);
    end
    step();
    exp_cnt = exp_cnt + 32'd2;
    checks++;
    if (stall_cnt !== exp_cnt) begin
      failures++; $display("FAIL branch_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  // A mult/div enters E alongside an HI/LO user in D; E is then cleared to a nop
  // as the real pipeline would do under IR_E_Clr.
  task automatic test_md(input string name, input logic [31:0] op_e,
                         input logic [31:0] op_d, input int busy_cycles);
    int n_stall;
    drive(op_d, op_e, 32'd0);
    checks++;
    if (stall !== 1'b1 || md_busy !== 1'b0) begin
      failures++; $display("FAIL %s_start: stall=%b busy=%b want 1/0", name, stall, md_busy);
    end
    step();
    drive(op_d, 32'd0, 32'd0);
    n_stall = 1;
    for (int i = 0; i < busy_cycles; i++) begin
      checks++;
      if (md_busy !== 1'b1 || stall !== 1'b1) begin
        failures++;
        $display("FAIL %s_busy%0d: busy=%b stall=%b want 1/1", name, i, md_busy, stall);
      end
      n_stall++;
      step();
    end
    checks++;
    if (md_busy !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL %s_done: busy=%b stall=%b want 0/0", name, md_busy, stall);
    end
    exp_cnt = exp_cnt + 32'(n_stall);
    checks++;
    if (stall_cnt !== exp_cnt) begin
      failures++; $display("FAIL %s_cnt: got %0d want %0d", name, stall_cnt, exp_cnt);
    end
    step();
    drive(32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_zero_store();
    drive(rtype(0, 0, 2, 6'h21), itype(6'h23, 1, 0, 16'h0), 32'd0);
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL zero_reg: got %b want 0", stall);
    end
    step();
    drive(itype(6'h2b, 6, 5, 16'h0), rtype(1, 2, 5, 6'h21), 32'd0);
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL sw_rt_alu: got %b want 0", stall);
    end
    step();
    drive(itype(6'h2b, 6, 5, 16'h0), itype(6'h23, 0, 5, 16'h0), 32'd0);
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL sw_rt_lw: got %b want 0", stall);
    end
    step();
    drive(itype(6'h2b, 6, 5, 16'h0), itype(6'h23, 0, 6, 16'h0), 32'd0);
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL sw_base_lw: got %b want 1", stall);
    end
    step();
    exp_cnt = exp_cnt + 32'd1;
    drive(32'd0, 32'd0, 32'd0);
    checks++;
    if (stall_cnt !== exp_cnt) begin
      failures++; $display("FAIL zero_store_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  // Both a data hazard and the MD busy condition in the same cycle count once.
  task automatic test_back_to_back();
    drive(32'd0, rtype(7, 8, 0, 6'h18), 32'd0);
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL combo_idle_d: got %b want 0", stall);
    end
    step();
    drive(rtype(1, 0, 0, 6'h11), itype(6'h23, 0, 1, 16'h0), 32'd0);
    checks++;
    if (stall !== 1'b1 || md_busy !== 1'b1) begin
      failures++; $display("FAIL combo_both: stall=%b busy=%b want 1/1", stall, md_busy);
    end
    step();
    exp_cnt = exp_cnt + 32'd1;
    drive(32'd0, 32'd0, 32'd0);
    checks++;
    if (stall_cnt !== exp_cnt) begin
      failures++; $display("FAIL combo_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (md_busy !== 1'b0) begin
      failures++; $display("FAIL combo_drain: got %b want 0", md_busy);
    end
  endtask

  task automatic test_async_reset();
    drive(32'd0, rtype(1, 2, 0, 6'h1b), 32'd0);
    step();
    drive(32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (md_busy !== 1'b1) begin
      failures++; $display("FAIL areset_pre_busy: got %b want 1", md_busy);
    end
    drive(rtype(0, 0, 3, 6'h12), rtype(1, 2, 0, 6'h18), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (md_busy !== 1'b0 || stall !== 1'b0 || ir_e_clr !== 1'b0 || stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL areset_now: busy=%b stall=%b clr=%b cnt=%0d want 0/0/0/0",
               md_busy, stall, ir_e_clr, stall_cnt);
    end
    drive(rtype(0, 0, 3, 6'h12), 32'd0, 32'd0);
    rst_n = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || md_busy !== 1'b0) begin
      failures++; $display("FAIL areset_mflo: stall=%b busy=%b want 0/0", stall, md_busy);
    end
    step();
    exp_cnt = 32'd0;
    checks++;
    if (stall_cnt !== exp_cnt) begin
      failures++; $display("FAIL areset_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ir_d = 32'd0;
    ir_e = 32'd0;
    ir_m = 32'd0;
    exp_cnt = 32'd0;
    test_reset();
    test_load_use();
    test_branch();
    test_md("mult", rtype(1, 2, 0, 6'h18), rtype(0, 0, 3, 6'h12), 5);
    test_md("divu", rtype(1, 2, 0, 6'h1b), rtype(4, 0, 0, 6'h11), 10);
    test_zero_store();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline.
- Decodes the instructions in D, E and M using Tuse/Tnew rules and tracks the multiply/divide unit's busy interval.
- Freezes PC and IF/ID and clears the instruction entering ID/EX (IR_E_Clr) when an operand cannot be forwarded in time.
- Keeps a stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu leaves E.
- DIV_CYCLES, 10, busy cycles after div/divu leaves E.
- CNT_W, 4, width of the busy counter; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- IR_D  in  32  instruction in ID.
- IR_E  in  32  instruction in EX (ID/EX output).
- IR_M  in  32  instruction in MEM.
- Stall  out  1  hold PC and IF/ID this cycle.
- IR_E_Clr  out  1  load a nop into ID/EX this cycle; always equals Stall.
- MD_Busy  out  1  mult/div unit busy.
- Stall_Cnt  out  32  count of cycles with Stall=1.

Behaviour:
- Decoded set (op/funct in hex), anything else treated as a nop with no reads and no writes:
  - addu 00/21, subu 00/23, mfhi 00/10, mflo 00/12, mthi 00/11, mtlo 00/13, jr 00/08.
  - mult 00/18, multu 00/19, div 00/1a, divu 00/1b.
  - ori 0d, lui 0f, lw 23, sw 2b, beq 04, j 02, jal 03.
- Destination register:
  - addu/subu/mfhi/mflo -> rd.
  - ori/lui/lw -> rt.
  - jal -> 31.
  - A destination of 0 never causes a stall.
- Tnew (cycles until result is forwardable):
  - In E: lw=2; addu/subu/ori/lui/mfhi/mflo=1; jal=0.
  - In M: lw=1; all others 0.
- Tuse (cycles until operand is needed):
  - beq rs,rt=0; jr rs=0.
  - addu/subu rs,rt=1; ori/lw/mthi/mtlo rs=1; mult/div family rs,rt=1.
  - sw rs=1, rt=2.
- Data stall: D reads register r (r≠0) with Tuse t, and E writes r with Tnew_E>t, or M writes r with Tnew_M>t.
- MD stall:
  - Applies when D is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
  - Asserted if MD_Busy=1 or IR_E is mult/multu/div/divu.
- Output timing:
  - Stall = data stall OR MD stall; purely combinational from IR_D/IR_E/IR_M and the busy counter, same cycle.
  - IR_E_Clr = Stall.
- Busy counter md_cnt (CNT_W bits), updated on posedge Clk:
  - If IR_E is mult/multu: load MULT_CYCLES.
  - Else if IR_E is div/divu: load DIV_CYCLES.
  - Else if md_cnt≠0: decrement.
  - A new start in E overrides any remaining count (it cannot occur while busy, because the MD stall prevents it).
- MD_Busy = (md_cnt≠0), registered-derived.
- Stall_Cnt: increments by 1 on each posedge with Stall=1; wraps from 0xFFFFFFFF to 0.
- Reset low, at any time and independent of Clk:
  - md_cnt=0, MD_Busy=0, Stall_Cnt=0.
  - Stall and IR_E_Clr are forced to 0 while Reset=0.
  - An in-flight mult/div countdown is abandoned.
- Simultaneous causes: data and MD stall are ORed; Stall_Cnt counts the cycle once.
- Stall never depends on IR_W; W-stage results are always forwardable through the register file.

Test Plan:
- Load-use: IR_E=lw $1,0($0), IR_D=addu $2,$1,$3 -> Stall=IR_E_Clr=1 for one cycle. Next cycle (lw in M, nop in E) -> Stall=0. Stall_Cnt=1.
- Branch: IR_E=addu $1,$2,$3, IR_D=beq $1,$4 -> Stall=1. Then addu in M -> Stall=0. Separately, IR_M=lw $1, IR_D=beq $1,$0 -> Stall=1. IR_E=jal, IR_D=jr $31 -> Stall=0.
- Mult-busy: mult $1,$2 in E with mflo $3 in D -> Stall=1 in that cycle, then MD_Busy=1 for exactly 5 cycles. Total of 6 stall cycles; Stall_Cnt=6; mflo released on cycle 7.
- Div: divu in E with mthi in D -> 11 stall cycles total, MD_Busy high for 10.
- Zero register and store: IR_E=lw $0,0($1), IR_D=addu $2,$0,$0 -> Stall=0. IR_E=addu $5,..., IR_D=sw $5,0($6) (rt Tuse 2) -> Stall=0.
- Async reset: Reset driven low mid-way through a div countdown (md_cnt=6), between clock edges -> MD_Busy=0, Stall=0, Stall_Cnt=0 immediately. After release, mflo in D -> no stall.
